xsim_dma_arbiter: RTL and testbench
===================================

// Module: xsim_dma_arbiter
// PURPOSE
//  Shares one XsimDmaReadWrite instance (single read-request, read-response and write32 port) among
//  NUM_CLIENTS requesters in the simulation top. Round-robin grant of one read or write per cycle;
//  an in-order tag FIFO routes each read response back to the client that issued it.
// PARAMETERS
//  NUM_CLIENTS  4   requesters sharing the DMA port (2..8)
//  TAG_DEPTH    4   outstanding reads tracked (power of 2, >=2)
// PORTS
//  CLK                  in   1         clock
//  RST                  in   1         synchronous reset, active-high
//  req_valid            in   N         client i has a request
//  req_ready            out  N         request i accepted this cycle (one-hot or zero)
//  req_write            in   N         1=write32, 0=read
//  req_handle           in   N*32      DMA handle, client i at [32i+:32]
//  req_addr             in   N*32      byte address
//  req_data             in   N*32      write data (ignored for reads)
//  rsp_valid            out  N         read data valid for client i (at most one bit set)
//  rsp_ready            in   N         client i takes the response
//  rsp_data             out  32        shared read data
//  dma_rdy_readrequest  in   1         from DMA: read request may issue
//  dma_en_readrequest   out  1         read request strobe
//  dma_readrequest_addr / _handle    out 32 each
//  dma_rdy_readresponse in   1         DMA holds valid read data
//  dma_en_readresponse  out  1         consume DMA read data
//  dma_readresponse_data in  32
//  dma_en_write32       out  1         write strobe (DMA always accepts)
//  dma_write32_addr / _handle / _data out 32 each
//  orphan_drop          out  1         sticky: DMA response arrived with no tag outstanding
// BEHAVIOUR
//  - Reset: rr_ptr=0, tag FIFO empty, orphan_drop=0; all strobes, req_ready, rsp_valid are 0 in reset.
//  - Eligibility: client i eligible if req_valid[i] and (req_write[i] or (dma_rdy_readrequest and !tag_full)).
//  - Grant: first eligible client scanning from rr_ptr upward modulo N; combinational, same cycle.
//    req_ready = one-hot of winner. On grant rr_ptr <= winner+1 (wraps N-1 -> 0); no grant: hold.
//  - Write grant: dma_en_write32=1 with winner's handle/addr/data; no tag pushed.
//  - Read grant: dma_en_readrequest=1 with winner's handle/addr; push winner id into tag FIFO.
//  - Ineligible reads do not block: a lower-priority eligible write wins over a stalled read.
//  - Response: if dma_rdy_readresponse and tag FIFO non-empty: rsp_valid[head]=1, rsp_data=dma data;
//    dma_en_readresponse = rsp_ready[head]; pop tag on that same cycle. Response latency from
//    read grant = 1 cycle min (DMA registers data).
//  - Simultaneous push and pop permitted; tag_full evaluated on registered count (no pass-through
//    when full). Issue+retire same cycle relies on DMA rdy_readrequest = !valid || en_readresponse
//    (combinational rsp_ready -> en_readresponse -> rdy_readrequest -> grant path, no loop).
//  - Orphan: dma_rdy_readresponse with FIFO empty -> dma_en_readresponse=1 (discard), orphan_drop<=1.
//    Covers reset asserted mid-read while DMA kept data.
//  - Reset mid-operation: outstanding tags discarded, no response delivered to any client afterwards.
//  - Address/data pass unmodified; no width arithmetic beyond log2 id and count (TAG_DEPTH+1 states).
// STRUCTURE
//  - Package xsim_dma_pkg: CLIENT_ID_W=$clog2(NUM_CLIENTS_MAX=8), typedef client_id_t,
//    typedef struct {handle, addr, data, write} dma_req_t.
//  - Sub-module xsim_tag_fifo: sync FIFO of client_id_t, push/pop/full/empty/head, sync active-high RST.
//  - Top: round-robin picker (comb), grant muxes, response demux, orphan flag.
// TESTING
//  - Single read: c2 read h=1 a=0x40, DMA returns 0xDEADBEEF -> rsp_valid=4'b0100, data 0xDEADBEEF, 1 tag pop.
//  - Fairness: all 4 clients write continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle.
//  - Backpressure: c1 read, rsp_ready[1]=0 for 5 cycles -> rsp_valid held, data stable, c0 read stalled
//    (rdy_readrequest=0) while c3 write still granted each cycle.
//  - Back-to-back: c0 read every cycle with rsp_ready=1 -> one request and one response per cycle,
//    responses in order, tag count never exceeds 1.
//  - Orphan: RST pulsed 1 cycle after read grant, DMA still asserts rdy_readresponse -> en_readresponse=1,
//    no rsp_valid, orphan_drop=1 until next RST.
//  - Wrap: rr_ptr=3, requests from c3 and c0 -> c3 granted, then c0, rr_ptr returns to 1.

Source files
------------

// File: rtl/xsim_dma_pkg.sv
// Shared types for the DMA arbiter: client id width and the per-client request bundle.
package xsim_dma_pkg;

  localparam int NUM_CLIENTS_MAX = 8;
  localparam int CLIENT_ID_W     = $clog2(NUM_CLIENTS_MAX);

  typedef logic [CLIENT_ID_W-1:0] client_id_t;

  typedef struct packed {
    logic [31:0] handle;
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
  } dma_req_t;

endpackage

// File: rtl/xsim_dma_arbiter_tag_fifo.sv
// In-order FIFO of client ids, one entry per outstanding DMA read.
module xsim_tag_fifo
  import xsim_dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  client_id_t push_id_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output client_id_t head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  client_id_t             mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/xsim_dma_arbiter.sv
// Round-robin sharing of one DMA read/write port among several clients; read
// responses are steered back to their issuer through an in-order tag FIFO.
module xsim_dma_arbiter
  import xsim_dma_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_CLIENTS-1:0]    req_valid_i,
  output logic [NUM_CLIENTS-1:0]    req_ready_o,
  input  logic [NUM_CLIENTS-1:0]    req_write_i,
  input  logic [NUM_CLIENTS*32-1:0] req_handle_i,
  input  logic [NUM_CLIENTS*32-1:0] req_addr_i,
  input  logic [NUM_CLIENTS*32-1:0] req_data_i,
  output logic [NUM_CLIENTS-1:0]    rsp_valid_o,
  input  logic [NUM_CLIENTS-1:0]    rsp_ready_i,
  output logic [31:0]               rsp_data_o,
  input  logic                      dma_rdy_readrequest_i,
  output logic                      dma_en_readrequest_o,
  output logic [31:0]               dma_readrequest_addr_o,
  output logic [31:0]               dma_readrequest_handle_o,
  input  logic                      dma_rdy_readresponse_i,
  output logic                      dma_en_readresponse_o,
  input  logic [31:0]               dma_readresponse_data_i,
  output logic                      dma_en_write32_o,
  output logic [31:0]               dma_write32_addr_o,
  output logic [31:0]               dma_write32_handle_o,
  output logic [31:0]               dma_write32_data_o,
  output logic                      orphan_drop_o
);

  client_id_t                  rr_ptr_q, rr_ptr_d;
  client_id_t                  winner, tag_head;
  logic                        grant_vld;
  logic                        tag_full, tag_empty, tag_push, tag_pop;
  logic                        orphan_q, orphan_d, rsp_live;
  logic [NUM_CLIENTS_MAX-1:0]  elig_ext, rsp_ready_ext;
  logic [CLIENT_ID_W:0]        scan_idx;
  dma_req_t                    sel_req;

  // A read is only eligible when both the DMA and a free tag slot can take it,
  // so a stalled read never shadows a write further round the ring.
  always_comb begin
    elig_ext = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      elig_ext[i] = req_valid_i[i] & (req_write_i[i] | (dma_rdy_readrequest_i & ~tag_full));
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    winner    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (CLIENT_ID_W+1)'(k);
      if (scan_idx >= (CLIENT_ID_W+1)'(NUM_CLIENTS))
        scan_idx = scan_idx - (CLIENT_ID_W+1)'(NUM_CLIENTS);
      if (!grant_vld && elig_ext[scan_idx[CLIENT_ID_W-1:0]]) begin
        grant_vld = 1'b1;
        winner    = scan_idx[CLIENT_ID_W-1:0];
      end
    end
    if (rst_i) grant_vld = 1'b0;
  end

  always_comb begin
    sel_req     = '0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (winner == client_id_t'(i)) begin
        sel_req.handle = req_handle_i[32*i +: 32];
        sel_req.addr   = req_addr_i[32*i +: 32];
        sel_req.data   = req_data_i[32*i +: 32];
        sel_req.write  = req_write_i[i];
        req_ready_o[i] = grant_vld;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld)
      rr_ptr_d = (winner == client_id_t'(NUM_CLIENTS-1)) ? '0 : winner + client_id_t'(1);
  end

  assign dma_en_write32_o         = grant_vld & sel_req.write;
  assign dma_en_readrequest_o     = grant_vld & ~sel_req.write;
  assign dma_write32_handle_o     = sel_req.handle;
  assign dma_write32_addr_o       = sel_req.addr;
  assign dma_write32_data_o       = sel_req.data;
  assign dma_readrequest_handle_o = sel_req.handle;
  assign dma_readrequest_addr_o   = sel_req.addr;
  assign tag_push                 = dma_en_readrequest_o;

  // With no tag outstanding the DMA data belongs to nobody and is drained.
  assign rsp_ready_ext         = NUM_CLIENTS_MAX'(rsp_ready_i);
  assign rsp_live              = ~rst_i & dma_rdy_readresponse_i;
  assign dma_en_readresponse_o = rsp_live & (tag_empty | rsp_ready_ext[tag_head]);
  assign tag_pop               = dma_en_readresponse_o & ~tag_empty;
  assign rsp_data_o            = dma_readresponse_data_i;
  assign orphan_d              = orphan_q | (rsp_live & tag_empty);
  assign orphan_drop_o         = orphan_q;

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      rsp_valid_o[i] = rsp_live & ~tag_empty & (tag_head == client_id_t'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      orphan_q <= orphan_d;
    end
  end

  xsim_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (tag_push),
    .push_id_i (winner),
    .pop_i     (tag_pop),
    .full_o    (tag_full),
    .empty_o   (tag_empty),
    .head_o    (tag_head)
  );

endmodule

// File: tb/tb_xsim_dma_arbiter.sv
// Randomized bench for xsim_dma_arbiter: a queue-based DMA model drives the port and a
// round-robin/tag-queue reference model predicts every grant and response.
module tb_xsim_dma_arbiter;

  localparam int N  = 4;
  localparam int TD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_handle, req_addr, req_data;
  logic [31:0]     rsp_data;
  logic            dma_rdy_readrequest, dma_en_readrequest;
  logic [31:0]     dma_readrequest_addr, dma_readrequest_handle;
  logic            dma_rdy_readresponse, dma_en_readresponse;
  logic [31:0]     dma_readresponse_data;
  logic            dma_en_write32;
  logic [31:0]     dma_write32_addr, dma_write32_handle, dma_write32_data;
  logic            orphan_drop;

  int          n_tests = 0;
  int          n_fail  = 0;

  // DMA side: a response queue of capacity dma_cap; cap 1 behaves as the real DMA.
  logic [31:0] dq[$];
  int          dma_cnt = 0;
  int          dma_cap = 1;
  logic        dma_stall = 1'b0;

  // Reference model: round-robin pointer, outstanding client ids and their expected data.
  int          m_rr = 0;
  int          m_q[$];
  logic [31:0] m_dq[$];
  bit          m_orphan = 1'b0;

  always #5 clk = ~clk;

  assign dma_rdy_readrequest = !dma_stall && ((dma_cnt < dma_cap) || dma_en_readresponse);

  xsim_dma_arbiter #(.NUM_CLIENTS(N), .TAG_DEPTH(TD)) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .req_valid_i              (req_valid),
    .req_ready_o              (req_ready),
    .req_write_i              (req_write),
    .req_handle_i             (req_handle),
    .req_addr_i               (req_addr),
    .req_data_i               (req_data),
    .rsp_valid_o              (rsp_valid),
    .rsp_ready_i              (rsp_ready),
    .rsp_data_o               (rsp_data),
    .dma_rdy_readrequest_i    (dma_rdy_readrequest),
    .dma_en_readrequest_o     (dma_en_readrequest),
    .dma_readrequest_addr_o   (dma_readrequest_addr),
    .dma_readrequest_handle_o (dma_readrequest_handle),
    .dma_rdy_readresponse_i   (dma_rdy_readresponse),
    .dma_en_readresponse_o    (dma_en_readresponse),
    .dma_readresponse_data_i  (dma_readresponse_data),
    .dma_en_write32_o         (dma_en_write32),
    .dma_write32_addr_o       (dma_write32_addr),
    .dma_write32_handle_o     (dma_write32_handle),
    .dma_write32_data_o       (dma_write32_data),
    .orphan_drop_o            (orphan_drop)
  );

  function automatic logic [31:0] rd_value(input logic [31:0] h, input logic [31:0] a);
    return a ^ {h[15:0], h[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int cyc);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    int          win, pv, pw, pr, idx;
    bit          exp_en_rsp, exp_rdy_rr, had_rsp;
    logic [31:0] exp_ready, exp_rsp_valid, s_rd_val, wh, wa, wd;
    logic        s_en_rr, s_en_rsp;

    rst = 1'b1;
    req_valid = '0; req_write = '0; rsp_ready = '0;
    req_handle = '0; req_addr = '0; req_data = '0;
    dma_rdy_readresponse = 1'b0; dma_readresponse_data = '0;
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 1600; cyc++) begin
      // Phase A: real DMA, stalls and resets; B: deep DMA to fill the tags; C: all clients write.
      if (cyc < 700) begin
        dma_cap = 1; pv = 60; pw = 40; pr = 70;
        dma_stall = ($urandom_range(99) < 10);
        rst = (cyc < 2) || (cyc < 690 && $urandom_range(99) < 3);
      end else if (cyc < 1400) begin
        dma_cap = 6; pv = 70; pw = 20; pr = 25;
        dma_stall = 1'b0; rst = 1'b0;
      end else begin
        pv = 100; pw = 100; pr = 100;
        dma_stall = 1'b0; rst = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(99) < pv);
        req_write[i] = ($urandom_range(99) < pw);
        rsp_ready[i] = ($urandom_range(99) < pr);
        req_handle[32*i +: 32] = $urandom;
        req_addr[32*i +: 32]   = $urandom;
        req_data[32*i +: 32]   = $urandom;
      end
      dma_rdy_readresponse  = (dq.size() > 0);
      dma_readresponse_data = (dq.size() > 0) ? dq[0] : 32'h0;

      @(negedge clk);
      had_rsp    = (dq.size() > 0);
      exp_en_rsp = !rst && had_rsp && (m_q.size() == 0 || rsp_ready[m_q[0]]);
      exp_rdy_rr = !dma_stall && ((dq.size() < dma_cap) || exp_en_rsp);
      win = -1;
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (win < 0 && req_valid[idx] && (req_write[idx] || (exp_rdy_rr && m_q.size() < TD)))
            win = idx;
        end
      end
      exp_ready     = (win >= 0) ? (32'd1 << win) : 32'd0;
      exp_rsp_valid = (!rst && had_rsp && m_q.size() > 0) ? (32'd1 << m_q[0]) : 32'd0;

      chk("req_ready", 32'(req_ready), exp_ready, cyc);
      chk("en_write32", 32'(dma_en_write32), 32'(win >= 0 && req_write[win]), cyc);
      chk("en_readrequest", 32'(dma_en_readrequest), 32'(win >= 0 && !req_write[win]), cyc);
      if (win >= 0) begin
        wh = req_handle[32*win +: 32];
        wa = req_addr[32*win +: 32];
        wd = req_data[32*win +: 32];
        if (req_write[win]) begin
          chk("write_handle", dma_write32_handle, wh, cyc);
          chk("write_addr", dma_write32_addr, wa, cyc);
          chk("write_data", dma_write32_data, wd, cyc);
        end else begin
          chk("read_handle", dma_readrequest_handle, wh, cyc);
          chk("read_addr", dma_readrequest_addr, wa, cyc);
        end
      end
      chk("rsp_valid", 32'(rsp_valid), exp_rsp_valid, cyc);
      if (exp_rsp_valid != 0) chk("rsp_data", rsp_data, m_dq[0], cyc);
      chk("en_readresponse", 32'(dma_en_readresponse), 32'(exp_en_rsp), cyc);
      chk("orphan_drop", 32'(orphan_drop), 32'(m_orphan), cyc);
      chk("tag_count_bound", 32'(m_q.size() <= TD), 32'd1, cyc);

      s_en_rr  = dma_en_readrequest;
      s_en_rsp = dma_en_readresponse;
      s_rd_val = rd_value(dma_readrequest_handle, dma_readrequest_addr);

      @(posedge clk); #1;
      if (s_en_rsp && dq.size() > 0) void'(dq.pop_front());
      if (s_en_rr) dq.push_back(s_rd_val);
      dma_cnt = dq.size();

      if (rst) begin
        m_q.delete();
        m_dq.delete();
        m_rr     = 0;
        m_orphan = 1'b0;
      end else begin
        if (had_rsp && m_q.size() == 0) m_orphan = 1'b1;
        if (exp_en_rsp && m_q.size() > 0) begin
          void'(m_q.pop_front());
          void'(m_dq.pop_front());
        end
        if (win >= 0) begin
          m_rr = (win + 1) % N;
          if (!req_write[win]) begin
            m_q.push_back(win);
            m_dq.push_back(rd_value(req_handle[32*win +: 32], req_addr[32*win +: 32]));
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
